button_debounce: RTL and testbench
==================================

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 The block SHALL have one parameter per line (name, default, meaning), as REQ-002 to REQ-004 below.
REQ-002 NUM_BUTTONS, 3, number of button channels.
REQ-003 DEBOUNCE_CYCLES, 20000, consecutive cycles a new level must persist before acceptance; legal range 2 to 2^20.
REQ-004 ACTIVE_LOW, 0, when 1 each raw input is inverted after synchronisation.
REQ-005 The block SHALL have one port per line (name, direction, width, meaning), as REQ-006 to REQ-013 below.
REQ-006 wb_clk_i, input, 1, sole clock.
REQ-007 wb_rst_i, input, 1, synchronous active-high reset.
REQ-008 buttons_raw, input, NUM_BUTTONS, asynchronous pad inputs from io_in.
REQ-009 buttons_clean, output, NUM_BUTTONS, debounced level; drives the buttons input of wb_buttons_leds.
REQ-010 press_pulse, output, NUM_BUTTONS, one-cycle strobe on each accepted 0->1 transition of buttons_clean.
REQ-011 release_pulse, output, NUM_BUTTONS, one-cycle strobe on each accepted 1->0 transition of buttons_clean.
REQ-012 irq_mask, input, NUM_BUTTONS, per-button press-interrupt enable.
REQ-013 irq_clr, input, 1, single-cycle strobe that clears all pending interrupts; irq, output, 1, level interrupt to user_irq[0].
REQ-014 The design SHALL use one clock, wb_clk_i; reset wb_rst_i SHALL be synchronous and active-high.

Function
REQ-015 Each buttons_raw bit SHALL pass through a 2-flop synchroniser, then an optional inversion per ACTIVE_LOW, giving sync[i].
REQ-016 Each channel SHALL hold a counter of width clog2(DEBOUNCE_CYCLES) and a stable bit that drives buttons_clean[i].
REQ-017 When sync[i]==stable[i], the counter SHALL load 0.
REQ-018 When sync[i]!=stable[i] and counter < DEBOUNCE_CYCLES-1, the counter SHALL increment.
REQ-019 When sync[i]!=stable[i] and counter == DEBOUNCE_CYCLES-1, the block SHALL set stable[i] <= sync[i] and counter <= 0; the counter SHALL never wrap.
REQ-020 A raw level first sampled at edge k and held SHALL appear on buttons_clean after edge k+DEBOUNCE_CYCLES+1.
REQ-021 A glitch whose synchronised width is shorter than DEBOUNCE_CYCLES cycles SHALL leave buttons_clean unchanged and return the counter to 0.
REQ-022 press_pulse[i] and release_pulse[i] SHALL be registered at the same edge that updates stable[i] and SHALL be high for exactly one cycle; they SHALL never both be high on one channel.
REQ-023 pending[i] SHALL set on press_pulse[i] & irq_mask[i]; irq SHALL equal |pending, combinationally from registers.
REQ-024 irq_clr SHALL clear all pending bits; on a simultaneous set and irq_clr, the set SHALL win for that bit.
REQ-025 Clearing irq_mask[i] SHALL NOT clear an already-set pending[i].
REQ-026 Channels SHALL operate independently; simultaneous transitions on several channels SHALL each produce their own pulse in the same cycle.

Reset
REQ-027 While wb_rst_i is high at a clock edge, synchroniser flops, stable bits, counters, pulses and pending bits SHALL all load 0; buttons_clean, press_pulse, release_pulse and irq SHALL all be 0 in the cycle after reset.
REQ-028 Reset asserted mid-count SHALL discard the partial count.
REQ-029 After reset release with sync[i]==1 (button held), a full DEBOUNCE_CYCLES qualification SHALL occur and then one press_pulse SHALL be produced.

Structure
REQ-030 Package button_pkg SHALL hold NUM_BUTTONS_DEFAULT and a function computing the counter width from DEBOUNCE_CYCLES.
REQ-031 Per-channel logic (synchroniser, counter, stable bit, edge pulses) SHALL live in sub-module debounce_cell, instantiated NUM_BUTTONS times.
REQ-032 Interrupt pending logic SHALL stay in the top module.

Verification (DEBOUNCE_CYCLES=4, NUM_BUTTONS=3, ACTIVE_LOW=0)
REQ-033 Raw[0] 0->1 sampled at edge 10 and held -> buttons_clean[0]=1 after edge 15; press_pulse[0]=1 for one cycle only.
REQ-034 Raw[1] high for 3 cycles, then low -> buttons_clean[1] stays 0; no pulses.
REQ-035 Raw[2] bounce 1,0,1,0 then steady 1 -> exactly one press_pulse[2], 5 edges after the final rising sample.
REQ-036 irq_mask=3'b001; press on buttons 0 and 1 -> irq=1 from button 0 only; irq_clr -> irq=0 next cycle; press and irq_clr in the same cycle -> irq stays 1.
REQ-037 wb_rst_i pulsed after counter reaches 2 -> outputs 0; with raw held, a press is accepted 5 edges after reset deassertion.
REQ-038 Release of a debounced button -> release_pulse for one cycle; pending unchanged.

Source files
------------

// File: rtl/button_pkg.sv
// button_pkg: shared defaults and counter sizing for the button debouncer
package button_pkg;
  localparam int NUM_BUTTONS_DEFAULT = 3;
  localparam int DEBOUNCE_MIN = 2;
  localparam int DEBOUNCE_MAX = 1 << 20;
  function automatic int cnt_width(input int cycles);
    return (cycles < DEBOUNCE_MIN) ? 1 : $clog2(cycles);
  endfunction
endpackage

// File: rtl/debounce_cell.sv
// debounce_cell: one channel -- synchroniser, persistence counter, stable level, edge strobes
module debounce_cell
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
);
  localparam int W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [W-1:0] LAST = W'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync_q;
  logic [W-1:0] cnt, cnt_d;
  logic s, accept;
  always_comb begin
    s = sync_q[1] ^ ACTIVE_LOW;
    accept = (s != clean) && (cnt == LAST);
    cnt_d = (s == clean || accept) ? '0 : cnt + W'(1);
  end
  // strobes are registered alongside the stable bit so they line up with the clean edge
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt <= '0;
      clean <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      cnt <= cnt_d;
      rise <= accept & s;
      fall <= accept & ~s;
      if (accept) clean <= s;
    end
  end
endmodule

// File: rtl/button_debounce.sv
// button_debounce: multi-channel debouncer with press/release strobes and masked press interrupt
module button_debounce
  import button_pkg::*;
#(
  parameter int NUM_BUTTONS = NUM_BUTTONS_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic [NUM_BUTTONS-1:0] buttons_raw,
  output logic [NUM_BUTTONS-1:0] buttons_clean,
  output logic [NUM_BUTTONS-1:0] press_pulse,
  output logic [NUM_BUTTONS-1:0] release_pulse,
  input  logic [NUM_BUTTONS-1:0] irq_mask,
  input  logic irq_clr,
  output logic irq
);
  logic [NUM_BUTTONS-1:0] pending;
  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_cell
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_cell (
      .clk(wb_clk_i),
      .rst(wb_rst_i),
      .raw(buttons_raw[g]),
      .clean(buttons_clean[g]),
      .rise(press_pulse[g]),
      .fall(release_pulse[g])
    );
  end
  // a new press outranks a simultaneous clear; unmasking never drops a pending bit
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) pending <= '0;
    else pending <= (pending & ~{NUM_BUTTONS{irq_clr}}) | (press_pulse & irq_mask);
  end
  assign irq = |pending;
endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: directed and random stimulus against a sliding-window reference model
module tb_button_debounce;
  localparam int NB = 3;
  localparam int D = 4;
  localparam bit AL = 1'b0;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NB-1:0] raw = '0;
  logic [NB-1:0] irq_mask = '0;
  logic irq_clr = 1'b0;
  logic [NB-1:0] clean, press, rel;
  logic irq;
  int tests = 0;
  int errors = 0;
  bit started = 0;

  button_debounce #(.NUM_BUTTONS(NB), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(AL)) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .buttons_raw(raw),
    .buttons_clean(clean),
    .press_pulse(press),
    .release_pulse(rel),
    .irq_mask(irq_mask),
    .irq_clr(irq_clr),
    .irq(irq)
  );

  always #5 clk = ~clk;

  // Model: a level is accepted once the last D synchronised samples all disagree with it.
  logic [NB-1:0] d1 = '0, d2 = '0, s_m;
  logic [NB-1:0] m_clean = '0, m_press = '0, m_rel = '0, m_pend = '0;
  bit win [NB][$];
  always @(posedge clk) begin
    started = 1;
    if (rst) begin
      d1 = '0; d2 = '0;
      m_clean = '0; m_press = '0; m_rel = '0; m_pend = '0;
      for (int i = 0; i < NB; i++) win[i].delete();
    end else begin
      s_m = d2 ^ {NB{AL}};
      m_pend = (m_pend & ~{NB{irq_clr}}) | (m_press & irq_mask);
      m_press = '0;
      m_rel = '0;
      for (int i = 0; i < NB; i++) begin
        bit acc;
        win[i].push_back(s_m[i]);
        if (win[i].size() > D) void'(win[i].pop_front());
        acc = (win[i].size() == D);
        for (int j = 0; j < win[i].size(); j++) if (win[i][j] == m_clean[i]) acc = 0;
        if (acc) begin
          m_clean[i] = s_m[i];
          m_press[i] = s_m[i];
          m_rel[i] = ~s_m[i];
        end
      end
      d2 = d1;
      d1 = raw;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (started) begin
        chk("model_clean", clean, m_clean);
        chk("model_press", press, m_press);
        chk("model_release", rel, m_rel);
        chk("model_irq", irq, |m_pend);
      end
    end
  endtask

  initial begin
    tick(3);
    chk("reset_clean", clean, 0);
    chk("reset_press", press, 0);
    chk("reset_irq", irq, 0);
    rst = 1'b0;
    // single press on button 0: clean rises exactly D+1 edges after first sample
    raw = 3'b001;
    tick(5);
    chk("b0_clean_early", clean[0], 0);
    tick(1);
    chk("b0_clean_set", clean[0], 1);
    chk("b0_press", press[0], 1);
    tick(1);
    chk("b0_press_one_cycle", press[0], 0);
    // short glitch on button 1 is rejected
    raw = 3'b011;
    tick(3);
    raw = 3'b001;
    tick(8);
    chk("b1_glitch_clean", clean[1], 0);
    // bounce on button 2 then steady high
    raw[2] = 1'b1; tick(1);
    raw[2] = 1'b0; tick(1);
    raw[2] = 1'b1; tick(1);
    raw[2] = 1'b0; tick(1);
    raw[2] = 1'b1;
    tick(5);
    chk("b2_press_early", press[2], 0);
    tick(1);
    chk("b2_press", press[2], 1);
    chk("b2_clean", clean[2], 1);
    tick(1);
    chk("b2_press_one_cycle", press[2], 0);
    // interrupts: only button 0 unmasked
    raw = '0;
    tick(8);
    irq_mask = 3'b001;
    raw = 3'b011;
    tick(6);
    chk("both_press", press, 3'b011);
    chk("irq_not_yet", irq, 0);
    tick(1);
    chk("irq_set", irq, 1);
    irq_clr = 1'b1; tick(1); irq_clr = 1'b0;
    chk("irq_cleared", irq, 0);
    raw = 3'b010;
    tick(8);
    raw = 3'b011;
    tick(6);
    chk("b0_repress", press[0], 1);
    irq_clr = 1'b1; tick(1); irq_clr = 1'b0;
    chk("set_beats_clr", irq, 1);
    irq_mask = '0;
    tick(2);
    chk("mask_keeps_pending", irq, 1);
    raw = 3'b010;
    tick(6);
    chk("b0_release", rel[0], 1);
    chk("release_no_irq_change", irq, 1);
    tick(1);
    chk("b0_release_one_cycle", rel[0], 0);
    irq_clr = 1'b1; tick(1); irq_clr = 1'b0;
    chk("irq_cleared_again", irq, 0);
    // reset mid-count discards the partial qualification
    raw = '0;
    tick(8);
    raw = 3'b100;
    tick(4);
    rst = 1'b1; tick(1); rst = 1'b0;
    chk("midreset_clean", clean, 0);
    chk("midreset_press", press, 0);
    tick(5);
    chk("post_reset_press_early", press[2], 0);
    tick(1);
    chk("post_reset_press", press[2], 1);
    // random phase
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NB; i++) if ($urandom_range(0, 5) == 0) raw[i] = ~raw[i];
      if ($urandom_range(0, 31) == 0) irq_mask = NB'($urandom);
      irq_clr = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 399) == 0);
      tick(1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
